bsg_manycore_pod_reset_sequencer: RTL and testbench

Sequences reset release across a num_pods_y_p x num_pods_x_p pod mesh array so pods leave reset one at a time. This spreads inrush current and lets boot traffic on the shared ver/hor/wh links start in a staggered way. The block sits beside the pod mesh array and drives one active-high reset per pod, which feeds each pod's reset dff chain in place of the tag-client reset. Host or tag logic starts a sequence with a valid/ready handshake and supplies a pod-enable mask.

---
 rtl/bsg_manycore_pod_reset_sequencer.sv | 151 +++++++++++++++
 tb/tb_bsg_manycore_pod_reset_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_pod_reset_sequencer.sv
// Staggered per-pod reset release for a pod mesh array: hold all pods, then release enabled pods
// one index at a time with an optional idle gap. BSG_MANYCORE_POD_RESET_SEQ_ABORT_EN adds abort_i.
`timescale 1ns/1ps

`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

module bsg_manycore_pod_reset_sequencer #(
    parameter int num_pods_x_p  = 4,
    parameter int num_pods_y_p  = 4,
    parameter int hold_cycles_p = 16,
    parameter int gap_cycles_p  = 8,
    localparam int num_pods_lp  = num_pods_x_p * num_pods_y_p,
    localparam int idx_w_lp     = `BSG_SAFE_CLOG2(num_pods_lp)
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   start_v_i,
    output logic                   start_ready_o,
    input  logic [num_pods_lp-1:0] pod_en_i,
`ifdef BSG_MANYCORE_POD_RESET_SEQ_ABORT_EN
    input  logic                   abort_i,
`endif
    output logic [num_pods_lp-1:0] pod_reset_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [idx_w_lp-1:0]    cur_pod_o
);

    localparam int hold_w_lp = `BSG_SAFE_CLOG2(hold_cycles_p + 1);
    localparam int gap_w_lp  = `BSG_SAFE_CLOG2(gap_cycles_p + 1);

    localparam logic [hold_w_lp-1:0] hold_last_lp = hold_w_lp'(hold_cycles_p - 1);
    localparam logic [gap_w_lp-1:0]  gap_last_lp  = gap_w_lp'(gap_cycles_p - 1);
    localparam logic [idx_w_lp-1:0]  idx_last_lp  = idx_w_lp'(num_pods_lp - 1);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StHold    = 3'd1;
    localparam logic [2:0] StRelease = 3'd2;
    localparam logic [2:0] StGap     = 3'd3;
    localparam logic [2:0] StDone    = 3'd4;

    logic [2:0]             state_q, state_d;
    logic [num_pods_lp-1:0] mask_q, mask_d;
    logic [num_pods_lp-1:0] pod_reset_q, pod_reset_d;
    logic [idx_w_lp-1:0]    idx_q, idx_d;
    logic [hold_w_lp-1:0]   hold_q, hold_d;
    logic [gap_w_lp-1:0]    gap_q, gap_d;
    logic                   abort_w;
    logic                   rel_w;

`ifdef BSG_MANYCORE_POD_RESET_SEQ_ABORT_EN
    assign abort_w = abort_i;
`else
    assign abort_w = 1'b0;
`endif

    assign rel_w = mask_q[idx_q];

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        pod_reset_d = pod_reset_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        gap_d       = gap_q;
        case (state_q)
            StIdle: begin
                if (start_v_i) begin
                    mask_d      = pod_en_i;
                    pod_reset_d = '1;
                    hold_d      = '0;
                    state_d     = StHold;
                end
            end
            StHold: begin
                if (hold_q == hold_last_lp) begin
                    hold_d  = '0;
                    idx_d   = '0;
                    state_d = StRelease;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StRelease: begin
                if (rel_w) begin
                    pod_reset_d[idx_q] = 1'b0;
                end
                if (idx_q == idx_last_lp) begin
                    state_d = StDone;
                end else if (rel_w && (gap_cycles_p > 0)) begin
                    gap_d   = '0;
                    state_d = StGap;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StGap: begin
                if (gap_q == gap_last_lp) begin
                    gap_d   = '0;
                    idx_d   = idx_q + 1'b1;
                    state_d = StRelease;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            StDone: begin
                idx_d   = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort wins over any in-flight step and re-asserts every pod reset.
        if (abort_w && (state_q != StIdle)) begin
            state_d     = StIdle;
            pod_reset_d = '1;
            idx_d       = '0;
            hold_d      = '0;
            gap_d       = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q     <= StIdle;
            mask_q      <= '0;
            pod_reset_q <= '1;
            idx_q       <= '0;
            hold_q      <= '0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            pod_reset_q <= pod_reset_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            gap_q       <= gap_d;
        end
    end

    assign start_ready_o = (state_q == StIdle);
    assign busy_o        = (state_q != StIdle);
    assign done_o        = (state_q == StDone) & ~abort_w;
    assign pod_reset_o   = pod_reset_q;
    assign cur_pod_o     = ((state_q == StRelease) || (state_q == StGap)) ? idx_q : '0;

endmodule

// File: tb/tb_bsg_manycore_pod_reset_sequencer.sv
// Directed bench for bsg_manycore_pod_reset_sequencer on a 2x2 array, hold=4, gap=2.
`timescale 1ns/1ps

module tb_bsg_manycore_pod_reset_sequencer;

    logic       clk;
    logic       reset_n;
    logic       start_v;
    logic       start_ready;
    logic [3:0] pod_en;
    logic [3:0] pod_reset;
    logic       busy;
    logic       done;
    logic [1:0] cur_pod;
`ifdef BSG_MANYCORE_POD_RESET_SEQ_ABORT_EN
    logic       abort;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    bsg_manycore_pod_reset_sequencer #(
        .num_pods_x_p (2),
        .num_pods_y_p (2),
        .hold_cycles_p(4),
        .gap_cycles_p (2)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .start_v_i    (start_v),
        .start_ready_o(start_ready),
        .pod_en_i     (pod_en),
`ifdef BSG_MANYCORE_POD_RESET_SEQ_ABORT_EN
        .abort_i      (abort),
`endif
        .pod_reset_o  (pod_reset),
        .busy_o       (busy),
        .done_o       (done),
        .cur_pod_o    (cur_pod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic [3:0] mask;
        logic [3:0] rst;
        logic       done;
        logic       ready;
        logic       busy;
        logic [1:0] cur;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic s, logic [3:0] m, logic [3:0] r, logic d, logic rdy,
                                logic b, logic [1:0] c);
        vec_t v;
        v.start = s; v.mask = m; v.rst = r; v.done = d; v.ready = rdy; v.busy = b; v.cur = c;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges, then check the idle/reset state in the following cycle.
    task automatic do_reset();
        reset_n = 1'b0;
        start_v = 1'b0;
        pod_en  = 4'h0;
`ifdef BSG_MANYCORE_POD_RESET_SEQ_ABORT_EN
        abort   = 1'b0;
`endif
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset pod_reset", 32'(pod_reset), 32'hF);
        chk("reset ready", 32'(start_ready), 32'h1);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset done", 32'(done), 32'h0);
        chk("reset cur_pod", 32'(cur_pod), 32'h0);
        next_cycle();
    endtask

    initial begin
        int done_cnt;
        int acc_cnt;

        // Run A: mask 1111, start in cycle 0.
        add(1, 4'hF, 4'hF, 0, 1, 0, 0);
        for (int k = 1; k <= 4; k++) add(0, 4'hF, 4'hF, 0, 0, 1, 0);
        add(0, 4'hF, 4'hF, 0, 0, 1, 0);
        add(0, 4'hF, 4'hE, 0, 0, 1, 0);
        add(0, 4'hF, 4'hE, 0, 0, 1, 0);
        add(0, 4'hF, 4'hE, 0, 0, 1, 1);
        add(0, 4'hF, 4'hC, 0, 0, 1, 1);
        add(0, 4'hF, 4'hC, 0, 0, 1, 1);
        add(0, 4'hF, 4'hC, 0, 0, 1, 2);
        add(0, 4'hF, 4'h8, 0, 0, 1, 2);
        add(0, 4'hF, 4'h8, 0, 0, 1, 2);
        add(0, 4'hF, 4'h8, 0, 0, 1, 3);
        add(0, 4'hF, 4'h0, 1, 0, 1, 0);
        // Run B: mask 1010; mask input changes after start to prove it was latched.
        add(1, 4'hA, 4'h0, 0, 1, 0, 0);
        for (int k = 1; k <= 4; k++) add(0, 4'h0, 4'hF, 0, 0, 1, 0);
        add(0, 4'h0, 4'hF, 0, 0, 1, 0);
        add(0, 4'h0, 4'hF, 0, 0, 1, 1);
        add(0, 4'h0, 4'hD, 0, 0, 1, 1);
        add(0, 4'h0, 4'hD, 0, 0, 1, 1);
        add(0, 4'h0, 4'hD, 0, 0, 1, 2);
        add(0, 4'h0, 4'hD, 0, 0, 1, 3);
        add(0, 4'h0, 4'h5, 1, 0, 1, 0);
        // Run C: mask 0000.
        add(1, 4'h0, 4'h5, 0, 1, 0, 0);
        for (int k = 1; k <= 4; k++) add(0, 4'h0, 4'hF, 0, 0, 1, 0);
        for (int k = 0; k <= 3; k++) add(0, 4'h0, 4'hF, 0, 0, 1, 2'(k));
        add(0, 4'h0, 4'hF, 1, 0, 1, 0);
        add(0, 4'h0, 4'hF, 0, 1, 0, 0);

        do_reset();

        for (int i = 0; i < vecs.size(); i++) begin
            start_v = vecs[i].start;
            pod_en  = vecs[i].mask;
            @(negedge clk);
            chk($sformatf("vec%0d pod_reset", i), 32'(pod_reset), 32'(vecs[i].rst));
            chk($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].done));
            chk($sformatf("vec%0d ready", i), 32'(start_ready), 32'(vecs[i].ready));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].busy));
            chk($sformatf("vec%0d cur_pod", i), 32'(cur_pod), 32'(vecs[i].cur));
            next_cycle();
        end

        // start_v held high for cycles 0..20: only edges 0 and 16 accept.
        done_cnt = 0;
        acc_cnt  = 0;
        for (int c = 0; c <= 20; c++) begin
            start_v = 1'b1;
            pod_en  = 4'hF;
            @(negedge clk);
            if (done) done_cnt++;
            if (start_ready) acc_cnt++;
            if (c == 1) chk("held ready c1", 32'(start_ready), 32'h0);
            if (c == 15) chk("held done c15", 32'(done), 32'h1);
            if (c == 16) chk("held ready c16", 32'(start_ready), 32'h1);
            if (c == 17) begin
                chk("held pod_reset c17", 32'(pod_reset), 32'hF);
                chk("held busy c17", 32'(busy), 32'h1);
            end
            next_cycle();
        end
        chk("held accept count", 32'(acc_cnt), 32'd2);
        chk("held done count", 32'(done_cnt), 32'd1);

        // Synchronous reset at edge 10 of a 1111 run.
        do_reset();
        done_cnt = 0;
        for (int c = 0; c <= 25; c++) begin
            start_v = (c == 0);
            pod_en  = 4'hF;
            reset_n = (c != 10);
            @(negedge clk);
            if (done) done_cnt++;
            if (c == 10) chk("rst pod_reset c10", 32'(pod_reset), 32'hC);
            if (c == 11) begin
                chk("rst pod_reset c11", 32'(pod_reset), 32'hF);
                chk("rst busy c11", 32'(busy), 32'h0);
                chk("rst ready c11", 32'(start_ready), 32'h1);
            end
            if (c == 25) chk("rst pod_reset c25", 32'(pod_reset), 32'hF);
            next_cycle();
        end
        chk("rst done count", 32'(done_cnt), 32'd0);

`ifdef BSG_MANYCORE_POD_RESET_SEQ_ABORT_EN
        // Abort at edge 7.
        do_reset();
        done_cnt = 0;
        for (int c = 0; c <= 20; c++) begin
            start_v = (c == 0);
            pod_en  = 4'hF;
            abort   = (c == 7);
            @(negedge clk);
            if (done) done_cnt++;
            if (c == 8) begin
                chk("abort pod_reset c8", 32'(pod_reset), 32'hF);
                chk("abort busy c8", 32'(busy), 32'h0);
                chk("abort ready c8", 32'(start_ready), 32'h1);
            end
            next_cycle();
        end
        abort = 1'b0;
        chk("abort done count", 32'(done_cnt), 32'd0);

        // Abort during DONE suppresses the pulse.
        do_reset();
        for (int c = 0; c <= 16; c++) begin
            start_v = (c == 0);
            pod_en  = 4'hF;
            abort   = (c == 15);
            @(negedge clk);
            if (c == 15) chk("done-abort done c15", 32'(done), 32'h0);
            if (c == 16) begin
                chk("done-abort pod_reset c16", 32'(pod_reset), 32'hF);
                chk("done-abort ready c16", 32'(start_ready), 32'h1);
            end
            next_cycle();
        end
        abort = 1'b0;
`else
        // No abort port: the same run completes normally.
        do_reset();
        done_cnt = 0;
        for (int c = 0; c <= 16; c++) begin
            start_v = (c == 0);
            pod_en  = 4'hF;
            @(negedge clk);
            if (done) done_cnt++;
            if (c == 15) chk("noabort done c15", 32'(done), 32'h1);
            if (c == 16) chk("noabort pod_reset c16", 32'(pod_reset), 32'h0);
            next_cycle();
        end
        chk("noabort done count", 32'(done_cnt), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
